// File: rtl/cpu_press_gen.sv
// Computer-player key press generator: turns LFSR words into timed presses.
// Optional press counter output is enabled by defining CPU_PRESS_STATS_EN.
module cpu_press_gen #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_PERIOD = 1024,
  parameter int PRESS_CYCLES  = 4,
  parameter int COOL_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] rnd,
  input  logic [WIDTH-2:0] thresh,
  output logic             press,
  output logic             press_pulse,
  output logic             busy
`ifdef CPU_PRESS_STATS_EN
  ,
  output logic [7:0]       press_cnt
`endif
);

  localparam int DIV_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int HOLD_W = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
  localparam int COOL_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PRESS_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'((COOL_CYCLES > 0) ? COOL_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [COOL_W-1:0] r_cool_cnt;
  logic              r_press;
  logic              r_press_pulse;
  logic              r_busy;

  logic w_strobe;
  logic w_hit;
  logic w_start;

  assign w_strobe = en & (r_div_cnt == DIV_LAST);
  assign w_hit    = w_strobe & (rnd < {1'b0, thresh});
  // Hits outside IDLE are dropped rather than queued.
  assign w_start  = w_hit & (r_state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (!en || (r_div_cnt == DIV_LAST)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_hold_cnt    <= '0;
      r_cool_cnt    <= '0;
      r_press       <= 1'b0;
      r_press_pulse <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_press_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state       <= HOLD;
            r_hold_cnt    <= HOLD_LOAD;
            r_press       <= 1'b1;
            r_press_pulse <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        HOLD: begin
          if (r_hold_cnt == '0) begin
            r_press <= 1'b0;
            if (COOL_CYCLES > 0) begin
              r_state    <= COOL;
              r_cool_cnt <= COOL_LOAD;
              r_busy     <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        COOL: begin
          if (r_cool_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cool_cnt <= r_cool_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_press <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign press       = r_press;
  assign press_pulse = r_press_pulse;
  assign busy        = r_busy;

`ifdef CPU_PRESS_STATS_EN
  logic [7:0] r_press_cnt;

  // Counts in step with press_pulse and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_press_cnt <= 8'd0;
    end else if (w_start && (r_press_cnt != 8'hFF)) begin
      r_press_cnt <= r_press_cnt + 8'd1;
    end
  end

  assign press_cnt = r_press_cnt;
`endif

endmodule

// File: tb/tb_cpu_press_gen.sv
// Self-checking bench for cpu_press_gen with a short sample period.
// Vector table covers compare boundaries; sequences cover timing corners.
`timescale 1ns/1ps
module tb_cpu_press_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [9:0] rnd;
  logic [8:0] thresh;
  logic       press;
  logic       press_pulse;
  logic       busy;
`ifdef CPU_PRESS_STATS_EN
  logic [7:0] press_cnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  cpu_press_gen #(
    .WIDTH(10),
    .SAMPLE_PERIOD(4),
    .PRESS_CYCLES(2),
    .COOL_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .rnd(rnd),
    .thresh(thresh),
    .press(press),
    .press_pulse(press_pulse),
    .busy(busy)
`ifdef CPU_PRESS_STATS_EN
    ,
    .press_cnt(press_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [9:0] rnd;
    logic [8:0] thresh;
    logic       en;
    int         expPress;
    int         expPulse;
    int         expBusy;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] r, input logic [8:0] t, input logic e);
    rnd    = r;
    thresh = t;
    en     = e;
  endtask

  // Leaves the bench at the sampling point of cycle 0 (clock low, divider at 0).
  task automatic resetDut();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pressCnt;
    int pulseCnt;
    int busyCnt;
    int pressAt4;
    int expP;

    rst = 1'b0;
    applyStimulus(10'd0, 9'd1, 1'b1);
    #1;
    checkOutput("resetPress", press, 0);
    checkOutput("resetPulse", press_pulse, 0);
    checkOutput("resetBusy", busy, 0);
`ifdef CPU_PRESS_STATS_EN
    checkOutput("resetPressCnt", press_cnt, 0);
`endif

    // Hits over 16 cycles: presses at 4-5 and 12-13, busy 4-8 and 12-15.
    vecs[0] = '{10'd10,   9'd100, 1'b1, 4, 2, 9};
    vecs[1] = '{10'd100,  9'd100, 1'b1, 0, 0, 0};
    vecs[2] = '{10'd99,   9'd100, 1'b1, 4, 2, 9};
    vecs[3] = '{10'd1023, 9'd511, 1'b1, 0, 0, 0};
    vecs[4] = '{10'd0,    9'd0,   1'b1, 0, 0, 0};
    vecs[5] = '{10'd0,    9'd1,   1'b1, 4, 2, 9};
    vecs[6] = '{10'd511,  9'd511, 1'b1, 0, 0, 0};
    vecs[7] = '{10'd510,  9'd511, 1'b1, 4, 2, 9};
    vecs[8] = '{10'd512,  9'd511, 1'b1, 0, 0, 0};
    vecs[9] = '{10'd0,    9'd511, 1'b0, 0, 0, 0};

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].rnd, vecs[v].thresh, vecs[v].en);
      resetDut();
      pressCnt = 0;
      pulseCnt = 0;
      busyCnt  = 0;
      pressAt4 = 0;
      for (int c = 0; c < 16; c++) begin
        if (press) pressCnt++;
        if (press_pulse) pulseCnt++;
        if (busy) busyCnt++;
        if (c == 4) pressAt4 = int'(press);
        nextCycle();
      end
      checkOutput($sformatf("vec%0d_pressCycles", v), pressCnt, vecs[v].expPress);
      checkOutput($sformatf("vec%0d_pulseCount", v), pulseCnt, vecs[v].expPulse);
      checkOutput($sformatf("vec%0d_busyCycles", v), busyCnt, vecs[v].expBusy);
      checkOutput($sformatf("vec%0d_pressAtCycle4", v), pressAt4, (vecs[v].expPress > 0) ? 1 : 0);
    end

    // Basic hit timing cycle by cycle.
    applyStimulus(10'd10, 9'd100, 1'b1);
    resetDut();
    for (int c = 0; c <= 10; c++) begin
      checkOutput($sformatf("basicPress_c%0d", c), press, (c == 4 || c == 5) ? 1 : 0);
      checkOutput($sformatf("basicPulse_c%0d", c), press_pulse, (c == 4) ? 1 : 0);
      if (c <= 8 || c == 10)
        checkOutput($sformatf("basicBusy_c%0d", c), busy, (c >= 4 && c <= 8) ? 1 : 0);
      nextCycle();
    end

    // Continuous hits: the strobe landing in COOL is skipped, period becomes 8.
    applyStimulus(10'd0, 9'd1, 1'b1);
    resetDut();
    for (int c = 0; c < 32; c++) begin
      expP = (c >= 4 && ((c - 4) % 8) < 2) ? 1 : 0;
      checkOutput($sformatf("periodicPress_c%0d", c), press, expP);
      checkOutput($sformatf("periodicPulse_c%0d", c), press_pulse,
                  (c >= 4 && ((c - 4) % 8) == 0) ? 1 : 0);
      nextCycle();
    end

    // rnd only matters at the strobe edge.
    applyStimulus(10'd0, 9'd100, 1'b1);
    resetDut();
    for (int c = 0; c < 9; c++) begin
      if (c == 3) rnd = 10'd1023;
      if (c == 4) begin
        checkOutput("sampleMissPress_c4", press, 0);
        rnd = 10'd0;
      end
      if (c == 8) checkOutput("sampleHitPress_c8", press, 1);
      nextCycle();
    end

    // Disabled for 20 cycles: no presses and divider parked at 0.
    applyStimulus(10'd0, 9'd511, 1'b0);
    resetDut();
    pressCnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (press) pressCnt++;
      nextCycle();
    end
    checkOutput("enOffPressCycles", pressCnt, 0);
    checkOutput("enOffDivCnt", int'(dut.r_div_cnt), 0);

    // Dropping en during HOLD lets the press finish, then nothing more.
    applyStimulus(10'd0, 9'd1, 1'b1);
    resetDut();
    repeat (4) nextCycle();
    checkOutput("enDropPress_c4", press, 1);
    en = 1'b0;
    nextCycle();
    checkOutput("enDropPress_c5", press, 1);
    nextCycle();
    checkOutput("enDropPress_c6", press, 0);
    pressCnt = 0;
    for (int c = 0; c < 24; c++) begin
      if (press) pressCnt++;
      nextCycle();
    end
    checkOutput("enDropLaterPresses", pressCnt, 0);
    checkOutput("enDropBusyEnd", busy, 0);

    // Asynchronous reset in the middle of HOLD, between clock edges.
    applyStimulus(10'd0, 9'd1, 1'b1);
    resetDut();
    repeat (4) nextCycle();
    checkOutput("asyncPreResetPress", press, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("asyncPress", press, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncPulse", press_pulse, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      checkOutput($sformatf("asyncRestartPress_c%0d", c), press, (c == 4) ? 1 : 0);
      if (c < 4) nextCycle();
    end

`ifdef CPU_PRESS_STATS_EN
    // 300+ presses at one per 8 cycles; counter must saturate.
    applyStimulus(10'd0, 9'd511, 1'b1);
    resetDut();
    repeat (2500) nextCycle();
    checkOutput("statsSaturated", press_cnt, 255);
    repeat (16) nextCycle();
    checkOutput("statsHeld", press_cnt, 255);
    en = 1'b0;
    repeat (4) nextCycle();
    checkOutput("statsKeptOnEnOff", press_cnt, 255);
    rst = 1'b0;
    #1;
    checkOutput("statsClearedOnReset", press_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
